// File: rtl/gba_link_tx.sv
// Host-side link transmitter: sends one 16-bit sound word, then one framebuffer
// of pixel dibits fetched from a synchronous pixel RAM, on din/wclk/write_en.
module gba_link_tx #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_WORDS = 19200
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] sound_in,
  output logic [14:0] pix_addr,
  output logic        pix_rd,
  input  logic [1:0]  pix_data,
  output logic        wclk,
  output logic        write_en,
  output logic [1:0]  din,
  output logic        busy,
  output logic        done
);

  localparam int             HW        = $clog2(CLK_DIV);
  localparam logic [HW-1:0]  HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [14:0]    SND_LAST  = 15'd7;
  localparam logic [14:0]    PIX_LAST  = 15'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SND, PIX, DONE} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [14:0]   bit_cnt;
  logic [15:0]   sound_sh;
  logic [1:0]    hold;
  logic          rd_d;
  logic [1:0]    next_pix;

  // With CLK_DIV=2 the RAM word arrives on the very edge that starts the next
  // slot, so it is forwarded straight from pix_data instead of the holding reg.
  assign next_pix = rd_d ? pix_data : hold;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      sound_sh <= '0;
      hold     <= '0;
      rd_d     <= 1'b0;
      pix_addr <= '0;
      pix_rd   <= 1'b0;
      wclk     <= 1'b0;
      write_en <= 1'b0;
      din      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pix_rd <= 1'b0;
      rd_d   <= pix_rd;
      if (rd_d) hold <= pix_data;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= SND;
            busy     <= 1'b1;
            din      <= sound_in[15:14];
            sound_sh <= {sound_in[13:0], 2'b00};
            bit_cnt  <= '0;
            half_cnt <= '0;
            wclk     <= 1'b0;
            write_en <= 1'b0;
          end
        end

        SND, PIX: begin
          if (half_cnt != HALF_LAST) begin
            half_cnt <= half_cnt + 1'b1;
          end else begin
            half_cnt <= '0;
            if (!wclk) begin
              // Rising half: prefetch the dibit needed by the next slot.
              wclk <= 1'b1;
              if (state == SND && bit_cnt == SND_LAST) begin
                pix_rd   <= 1'b1;
                pix_addr <= '0;
              end else if (state == PIX && bit_cnt != PIX_LAST) begin
                pix_rd   <= 1'b1;
                pix_addr <= bit_cnt + 15'd1;
              end
            end else begin
              wclk <= 1'b0;
              if (state == SND) begin
                if (bit_cnt == SND_LAST) begin
                  state    <= PIX;
                  bit_cnt  <= '0;
                  write_en <= 1'b1;
                  din      <= next_pix;
                end else begin
                  bit_cnt  <= bit_cnt + 15'd1;
                  din      <= sound_sh[15:14];
                  sound_sh <= {sound_sh[13:0], 2'b00};
                end
              end else if (bit_cnt == PIX_LAST) begin
                state    <= DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                write_en <= 1'b0;
                din      <= '0;
                pix_addr <= '0;
              end else begin
                bit_cnt <= bit_cnt + 15'd1;
                din     <= next_pix;
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_link_tx.sv
// Scoreboard bench for gba_link_tx: expected link dibits and RAM addresses are
// queued per frame and popped by a monitor with a behavioural receiver model.
module tb_gba_link_tx;

  localparam int D           = 2;
  localparam int N           = 128;
  localparam int FRAME_EDGES = (8 + N) * 2 * D;
  localparam int LIMIT       = FRAME_EDGES + 50;

  logic        clk      = 1'b0;
  logic        resetn   = 1'b0;
  logic        start    = 1'b0;
  logic [15:0] sound_in = '0;
  logic [14:0] pix_addr;
  logic        pix_rd;
  logic [1:0]  pix_data = '0;
  logic        wclk;
  logic        write_en;
  logic [1:0]  din;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0]  ram    [0:N-1];
  logic [1:0]  rx_ram [0:N-1];
  logic [2:0]  exp_link [$];
  logic [14:0] exp_addr [$];
  logic [2:0]  exp_e;
  logic [14:0] exp_a;
  logic [2:0]  link_q   = '0;
  logic        wclk_q   = 1'b0;
  logic        we_q     = 1'b0;
  logic [15:0] rx_shift = '0;
  int          rx_addr  = 0;
  int          rise_cnt = 0;
  int          rd_cnt   = 0;

  gba_link_tx #(.CLK_DIV(D), .NUM_WORDS(N)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .sound_in (sound_in),
    .pix_addr (pix_addr),
    .pix_rd   (pix_rd),
    .pix_data (pix_data),
    .wclk     (wclk),
    .write_en (write_en),
    .din      (din),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (pix_rd) pix_data <= (int'(pix_addr) < N) ? ram[pix_addr[6:0]] : 2'b00;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  // Queue the link dibits and RAM addresses one frame should produce.
  task automatic apply_stimulus(input logic [15:0] snd);
    for (int i = 0; i < 8; i++) exp_link.push_back({1'b0, snd[15-2*i -: 2]});
    for (int k = 0; k < N; k++) begin
      exp_link.push_back({1'b1, ram[k]});
      exp_addr.push_back(15'(k));
    end
  endtask

  // Monitor: pops expectations at every wclk rise and every read strobe.
  always @(negedge clk) begin
    if (wclk && wclk_q) check_output("stable_high", {write_en, din}, link_q);
    if (wclk && !wclk_q) begin
      rise_cnt++;
      if (exp_link.size() == 0) flag_fail("unexpected_rise");
      else begin
        exp_e = exp_link.pop_front();
        check_output("link_rise", {write_en, din}, exp_e);
      end
      if (!write_en) rx_shift = {rx_shift[13:0], din};
      else if (rx_addr < N) begin
        rx_ram[rx_addr] = din;
        rx_addr++;
      end
    end
    if (we_q && !write_en) rx_addr = 0;
    if (pix_rd) begin
      rd_cnt++;
      if (exp_addr.size() == 0) flag_fail("unexpected_rd");
      else begin
        exp_a = exp_addr.pop_front();
        check_output("pix_addr", pix_addr, exp_a);
      end
    end
    wclk_q = wclk;
    we_q   = write_en;
    link_q = {write_en, din};
  end

  // Entered at the negedge right after the accepting edge (n = 0).
  task automatic run_frame(input logic [15:0] snd, input bit poke);
    int n, busy_cnt, bad;
    bit seen;
    rise_cnt = 0;
    rd_cnt   = 0;
    n        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    check_output("first_slot", {busy, wclk, write_en, din}, {1'b1, 1'b0, 1'b0, snd[15:14]});
    while (!seen && n <= LIMIT) begin
      if (n == D - 1) check_output("low_half", wclk, 1'b0);
      if (n == D) check_output("first_rise", wclk, 1'b1);
      if (poke && n == 200) start = 1'b1;
      if (poke && n == 201) start = 1'b0;
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
        n++;
      end
    end
    check_output("done_seen", seen, 1'b1);
    check_output("done_edge", n, FRAME_EDGES);
    check_output("busy_cycles", busy_cnt, FRAME_EDGES);
    check_output("wclk_rises", rise_cnt, 8 + N);
    check_output("rd_strobes", rd_cnt, N);
    check_output("rx_sound", rx_shift, snd);
    check_output("rx_count", rx_addr, N);
    bad = 0;
    for (int k = 0; k < N; k++) if (rx_ram[k] !== ram[k]) bad++;
    check_output("rx_ram_errors", bad, 0);
    @(negedge clk);
    check_output("idle_after_done", {busy, done, wclk, write_en, din, pix_rd, pix_addr}, '0);
  endtask

  initial begin
    int idle_bad;
    for (int k = 0; k < N; k++) begin
      ram[k]    = k[1:0];
      rx_ram[k] = 2'b00;
    end

    // Reset held with start high: nothing may move.
    resetn   = 1'b0;
    start    = 1'b1;
    sound_in = 16'hA5C3;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_outputs", {pix_addr, pix_rd, wclk, write_en, din, busy, done}, '0);
    end
    check_output("reset_no_rise", rise_cnt, 0);

    // Release: the next edge accepts start; 16'hA5C3 goes out as 2,2,1,1,3,0,0,3.
    apply_stimulus(16'hA5C3);
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    run_frame(16'hA5C3, 1'b0);

    // Reset asserted in PIX slot 100, on the edge where wclk would have risen.
    apply_stimulus(16'h1E69);
    sound_in = 16'h1E69;
    start    = 1'b1;
    rise_cnt = 0;
    rd_cnt   = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (433) @(negedge clk);
    resetn = 1'b0;
    exp_link.delete();
    exp_addr.delete();
    check_output("mid_rises", rise_cnt, 108);
    check_output("mid_rd", rd_cnt, 101);
    @(negedge clk);
    check_output("mid_reset_out", {wclk, write_en, busy, pix_rd, done}, '0);

    // Restart with a new word; a start pulse during busy must be ignored.
    resetn   = 1'b1;
    sound_in = 16'h0F3C;
    start    = 1'b1;
    apply_stimulus(16'h0F3C);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    run_frame(16'h0F3C, 1'b1);

    // Back-to-back with start held; the second frame latches the later word.
    apply_stimulus(16'h5A96);
    apply_stimulus(16'h3C01);
    sound_in = 16'h5A96;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sound_in = 16'h3C01;
    run_frame(16'h5A96, 1'b0);
    @(negedge clk);
    start = 1'b0;
    run_frame(16'h3C01, 1'b0);
    idle_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || wclk) idle_bad++;
    end
    check_output("no_extra_frame", idle_bad, 0);
    check_output("queue_drained", exp_link.size() + exp_addr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
